// File: rtl/tracer_seq_pkg.sv
// tracer_seq_pkg: shared state encoding and tracer value generation for tracer_sequencer.
// Optional LFSR value mode is selected by TRACER_SEQ_LFSR_EN.
package tracer_seq_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, COOL = 2'd2} state_e;
   localparam logic [7:0] LFSR_MASK = 8'hB8;
   function automatic logic [7:0] first_val(input logic [7:0] seed);
`ifdef TRACER_SEQ_LFSR_EN
      return (seed == 8'h00) ? 8'h01 : seed;
`else
      return seed;
`endif
   endfunction
   function automatic logic [7:0] next_val(input logic [7:0] cur, input logic [7:0] step);
`ifdef TRACER_SEQ_LFSR_EN
      return (cur >> 1) ^ (cur[0] ? LFSR_MASK : (step & 8'h00));
`else
      return cur + step;
`endif
   endfunction
endpackage

// File: rtl/tracer_sequencer_if.sv
// tracer_sequencer_if: 8-bit tracer-vector AXI stream between sequencer and injector.
interface tracer_sequencer_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   modport master (output tdata, tvalid, input tready);
   modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/tracer_seq_wdog.sv
// tracer_seq_wdog: counts idle cycles and pulses expire when the live limit is about to be reached.
module tracer_seq_wdog #(
   parameter int WD_W = 16
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            clr,
   input  logic            en,
   input  logic [WD_W-1:0] limit,
   output logic            expire
);
   logic [WD_W-1:0] cnt_q, cnt_d;
   assign expire = en && (limit != '0) && (cnt_q == limit - WD_W'(1));
   always_comb cnt_d = clr ? '0 : en ? cnt_q + WD_W'(1) : cnt_q;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/tracer_sequencer.sv
// tracer_sequencer: start/stop sequenced tracer-value AXI stream source with run limit and stall watchdog.
// Define TRACER_SEQ_LFSR_EN to generate values with an 8-bit Galois LFSR instead of seed+n*step.
module tracer_sequencer
   import tracer_seq_pkg::*;
#(
   parameter int WD_W   = 16,
   parameter int FCNT_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              stop,
   input  logic [7:0]        seed,
   input  logic [7:0]        step,
   input  logic [FCNT_W-1:0] frame_limit,
   input  logic [WD_W-1:0]   wd_limit,
   input  logic              sof,
   tracer_sequencer_if.master axis_vector,
   output logic              busy,
   output logic [FCNT_W-1:0] values_sent,
   output logic [FCNT_W-1:0] frames_seen,
   output logic              stall
);
   state_e            state_q, state_d;
   logic [7:0]        tdata_q, tdata_d, step_q, step_d;
   logic              tvalid_q, tvalid_d, busy_q, busy_d, stall_q, stall_d;
   logic [FCNT_W-1:0] vs_q, vs_d, fs_q, fs_d, limit_q, limit_d, vs_inc, fs_inc;
   logic              run, hs, expire;
   assign run    = (state_q == RUN);
   assign hs     = tvalid_q && axis_vector.tready;
   assign vs_inc = (vs_q == '1) ? vs_q : vs_q + FCNT_W'(1);
   assign fs_inc = (fs_q == '1) ? fs_q : fs_q + FCNT_W'(1);
   tracer_seq_wdog #(.WD_W(WD_W)) u_wdog (
      .clk    (clk),
      .resetn (resetn),
      .clr    (!run || hs),
      .en     (run && !hs),
      .limit  (wd_limit),
      .expire (expire)
   );
   always_comb begin
      state_d = state_q;
      tdata_d = tdata_q;
      step_d  = step_q;
      limit_d = limit_q;
      vs_d    = vs_q;
      fs_d    = fs_q;
      stall_d = stall_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            tdata_d = first_val(seed);
            step_d  = step;
            limit_d = frame_limit;
            vs_d    = '0;
            fs_d    = '0;
            stall_d = 1'b0;
         end
         RUN: begin
            tdata_d = hs ? next_val(tdata_q, step_q) : tdata_q;
            vs_d    = hs ? vs_inc : vs_q;
            fs_d    = sof ? fs_inc : fs_q;
            stall_d = stall_q || expire;
            // stop wins over a same-cycle handshake, but that handshake is still counted above
            if (stop || expire || (limit_q != '0 && hs && vs_inc == limit_q)) state_d = COOL;
         end
         COOL: begin
            fs_d    = sof ? fs_inc : fs_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      tvalid_d = (state_d == RUN);
      busy_d   = (state_d != IDLE);
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state_q  <= IDLE;
         tdata_q  <= '0;
         step_q   <= '0;
         limit_q  <= '0;
         vs_q     <= '0;
         fs_q     <= '0;
         stall_q  <= 1'b0;
         tvalid_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tdata_q  <= tdata_d;
         step_q   <= step_d;
         limit_q  <= limit_d;
         vs_q     <= vs_d;
         fs_q     <= fs_d;
         stall_q  <= stall_d;
         tvalid_q <= tvalid_d;
         busy_q   <= busy_d;
      end
   assign axis_vector.tdata  = tdata_q;
   assign axis_vector.tvalid = tvalid_q;
   assign busy        = busy_q;
   assign values_sent = vs_q;
   assign frames_seen = fs_q;
   assign stall       = stall_q;
endmodule

// File: tb/tb_tracer_sequencer.sv
// tb_tracer_sequencer: scoreboard bench; expected tracer values are queued at start and popped per handshake.
module tb_tracer_sequencer;
   logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, stop = 1'b0, sof = 1'b0;
   logic [7:0]  seed = '0, step = '0;
   logic [31:0] frame_limit = '0;
   logic [15:0] wd_limit = '0;
   logic        busy, stall;
   logic [31:0] values_sent, frames_seen;
   int          checks = 0, failures = 0;
   logic [7:0]  sb_q[$];
   tracer_sequencer_if axis_vector();
   tracer_sequencer dut (
      .clk(clk), .resetn(resetn), .start(start), .stop(stop), .seed(seed), .step(step),
      .frame_limit(frame_limit), .wd_limit(wd_limit), .sof(sof), .axis_vector(axis_vector),
      .busy(busy), .values_sent(values_sent), .frames_seen(frames_seen), .stall(stall)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] m_first(input logic [7:0] s);
`ifdef TRACER_SEQ_LFSR_EN
      return (s == 8'h00) ? 8'h01 : s;
`else
      return s;
`endif
   endfunction
   function automatic logic [7:0] m_next(input logic [7:0] v, input logic [7:0] st);
`ifdef TRACER_SEQ_LFSR_EN
      logic [7:0] r;
      r = {1'b0, v[7:1]};
      if (v[0]) r = r ^ 8'hB8;
      return r;
`else
      return 8'(v + st);
`endif
   endfunction
   task automatic push_run(input logic [7:0] s, input logic [7:0] st, input int n);
      logic [7:0] v;
      v = m_first(s);
      for (int i = 0; i < n; i++) begin
         sb_q.push_back(v);
         v = m_next(v, st);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask
   always @(negedge clk)
      if (resetn && axis_vector.tvalid && axis_vector.tready) begin
         if (sb_q.size() == 0) chk("hs_unexpected", 0, 1);
         else chk("tdata", axis_vector.tdata, sb_q.pop_front());
      end
   initial begin
      axis_vector.tready = 1'b0;
      tick();
      chk("rst_tvalid", axis_vector.tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tdata", axis_vector.tdata, 0);
      resetn = 1'b1;
      tick();
      // limited run; frame_limit change mid-run must not matter
      seed = 8'h10; step = 8'd3; frame_limit = 4; axis_vector.tready = 1'b1;
      push_run(8'h10, 8'd3, 4);
      pulse_start();
      frame_limit = 0;
      repeat (3) tick();
      chk("t1_tvalid_run", axis_vector.tvalid, 1);
      tick();
      chk("t1_vs", values_sent, 4);
      chk("t1_tvalid_cool", axis_vector.tvalid, 0);
      chk("t1_busy_cool", busy, 1);
      tick();
      chk("t1_busy_idle", busy, 0);
      chk("t1_sb_empty", sb_q.size(), 0);
      // wrap and stop
      seed = 8'hFE; step = 8'd1; frame_limit = 0;
      push_run(8'hFE, 8'd1, 4);
      pulse_start();
      repeat (4) tick();
      chk("t2_vs_run", values_sent, 4);
      axis_vector.tready = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t2_tvalid_cool", axis_vector.tvalid, 0);
      chk("t2_busy_cool", busy, 1);
      tick();
      chk("t2_busy_idle", busy, 0);
      chk("t2_sb_empty", sb_q.size(), 0);
      // watchdog
      seed = 8'h20; wd_limit = 5;
      pulse_start();
      repeat (4) tick();
      chk("t3_stall_early", stall, 0);
      chk("t3_tvalid_run", axis_vector.tvalid, 1);
      tick();
      chk("t3_stall_set", stall, 1);
      chk("t3_tvalid_off", axis_vector.tvalid, 0);
      tick();
      chk("t3_stall_sticky", stall, 1);
      chk("t3_busy_idle", busy, 0);
      wd_limit = 0;
      pulse_start();
      chk("t3_stall_clr", stall, 0);
      chk("t3_tvalid_rerun", axis_vector.tvalid, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      // stop coincident with handshake; start during COOL
      seed = 8'h40; step = 8'd2; axis_vector.tready = 1'b1;
      push_run(8'h40, 8'd2, 3);
      pulse_start();
      repeat (2) tick();
      chk("t4_vs2", values_sent, 2);
      stop = 1'b1;
      tick();
      stop = 1'b0; axis_vector.tready = 1'b0;
      chk("t4_vs3", values_sent, 3);
      chk("t4_tvalid_cool", axis_vector.tvalid, 0);
      pulse_start();
      chk("t4_cool_start_busy", busy, 0);
      chk("t4_cool_start_tvalid", axis_vector.tvalid, 0);
      chk("t4_sb_empty", sb_q.size(), 0);
      // async reset mid-run
      seed = 8'h55; step = 8'd1;
      pulse_start();
      tick();
      chk("t5_tvalid_run", axis_vector.tvalid, 1);
      #2 resetn = 1'b0;
      #1;
      chk("t5_tvalid_rst", axis_vector.tvalid, 0);
      chk("t5_tdata_rst", axis_vector.tdata, 0);
      chk("t5_busy_rst", busy, 0);
      axis_vector.tready = 1'b1;
      tick(); tick();
      chk("t5_tvalid_held", axis_vector.tvalid, 0);
      resetn = 1'b1;
      tick();
      chk("t5_busy_after", busy, 0);
      // seed 0 (LFSR substitutes 0x01) and sof counting
      seed = 8'h00; step = 8'd7; frame_limit = 4;
      push_run(8'h00, 8'd7, 4);
      pulse_start();
      sof = 1'b1;
      repeat (3) tick();
      sof = 1'b0;
      tick();
      chk("t6_fs_run", frames_seen, 3);
      chk("t6_vs", values_sent, 4);
      sof = 1'b1;
      tick();
      sof = 1'b0;
      chk("t6_fs_cool", frames_seen, 4);
      sof = 1'b1;
      tick();
      sof = 1'b0;
      chk("t6_fs_idle", frames_seen, 4);
      chk("t6_sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
